// File: rtl/shift_sequencer_if.sv
// ---------------------------------------------------------------------------
// shift_sequencer_if: request, status and ALU bus of shift_sequencer. Rev 1.0
// Optional: SHIFT_SEQ_ABORT_EN adds the abort request line.
// ---------------------------------------------------------------------------
`default_nettype none

interface shift_sequencer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
);
  logic                  start;
  logic [1:0]            op;
  logic                  dir;
  logic [DATA_WIDTH-1:0] operand;
  logic [CNT_WIDTH-1:0]  amount;
`ifdef SHIFT_SEQ_ABORT_EN
  logic                  abort;
`endif
  logic [DATA_WIDTH-1:0] alu_data1;
  logic [DATA_WIDTH-1:0] alu_data2;
  logic [2:0]            alu_select;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  busy;
  logic                  done;
  logic                  error;
  logic [DATA_WIDTH-1:0] result;

`ifdef SHIFT_SEQ_ABORT_EN
  modport master (
    output start, op, dir, operand, amount, abort, alu_result,
    input  alu_data1, alu_data2, alu_select, busy, done, error, result
  );
  modport slave (
    input  start, op, dir, operand, amount, abort, alu_result,
    output alu_data1, alu_data2, alu_select, busy, done, error, result
  );
`else
  modport master (
    output start, op, dir, operand, amount, alu_result,
    input  alu_data1, alu_data2, alu_select, busy, done, error, result
  );
  modport slave (
    input  start, op, dir, operand, amount, alu_result,
    output alu_data1, alu_data2, alu_select, busy, done, error, result
  );
`endif
endinterface

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer: runs AMOUNT single-bit shift/rotate steps through an
// external ALU. Rev 1.0. Optional: SHIFT_SEQ_ABORT_EN adds an abort input.
// ---------------------------------------------------------------------------
`default_nettype none

module shift_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3
) (
  input  logic             clk,
  input  logic             reset,
  shift_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [1:0]            c_op_lsl      = 2'b00;
  localparam logic [1:0]            c_op_asl      = 2'b01;
  localparam logic [1:0]            c_op_rsvd     = 2'b11;
  localparam logic [2:0]            c_sel_none    = 3'b000;
  localparam logic [2:0]            c_sel_logical = 3'b101;
  localparam logic [2:0]            c_sel_arith   = 3'b110;
  localparam logic [2:0]            c_sel_rotate  = 3'b111;
  localparam logic [DATA_WIDTH-1:0] c_code_left   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] c_code_right  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0]  c_cnt_zero    = '0;
  localparam logic [CNT_WIDTH-1:0]  c_cnt_one     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_work;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [1:0]            r_op;
  logic                  r_dir;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [DATA_WIDTH-1:0] r_result;

  logic [DATA_WIDTH-1:0] w_alu_data1;
  logic [DATA_WIDTH-1:0] w_alu_data2;
  logic [2:0]            w_alu_select;
  logic                  w_abort;

`ifdef SHIFT_SEQ_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_work   <= '0;
      r_cnt    <= '0;
      r_op     <= '0;
      r_dir    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_result <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_work <= bus.operand;
            r_cnt  <= bus.amount;
            r_op   <= bus.op;
            r_dir  <= bus.dir;
            r_busy <= 1'b1;
            if ((bus.amount != c_cnt_zero) && (bus.op != c_op_rsvd)) begin
              r_state <= S_STEP;
            end else begin
              // Nothing to shift (or reserved op): finish with the operand untouched.
              r_state  <= S_FIN;
              r_done   <= 1'b1;
              r_error  <= (bus.op == c_op_rsvd);
              r_result <= bus.operand;
            end
          end
        end
        S_STEP: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_work <= bus.alu_result;
            r_cnt  <= r_cnt - c_cnt_one;
            if (r_cnt == c_cnt_one) begin
              // Publish the last ALU result so RESULT is valid alongside DONE.
              r_state  <= S_FIN;
              r_done   <= 1'b1;
              r_result <= bus.alu_result;
            end
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_alu_select = c_sel_none;
    w_alu_data1  = '0;
    w_alu_data2  = '0;
    if (r_state == S_STEP) begin
      w_alu_data1 = r_work;
      w_alu_data2 = r_dir ? c_code_right : c_code_left;
      case (r_op)
        c_op_lsl: w_alu_select = c_sel_logical;
        c_op_asl: w_alu_select = c_sel_arith;
        default:  w_alu_select = c_sel_rotate;
      endcase
    end
  end

  assign bus.alu_data1  = w_alu_data1;
  assign bus.alu_data2  = w_alu_data2;
  assign bus.alu_select = w_alu_select;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.result     = r_result;

endmodule

`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand/result width.
REQ-002 SHALL have parameter CNT_WIDTH, default 3, width of AMOUNT and the step counter.
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port RESET  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port START  input  1  request a multi-bit operation; sampled only in IDLE.
REQ-006 SHALL have port OP  input  2  00 logical shift, 01 arithmetic shift, 10 rotate, 11 reserved.
REQ-007 SHALL have port DIR  input  1  0 left, 1 right.
REQ-008 SHALL have port OPERAND  input  DATA_WIDTH  value to operate on.
REQ-009 SHALL have port AMOUNT  input  CNT_WIDTH  number of 1-bit steps, 0..7.
REQ-010 SHALL have port ALU_DATA1  output  DATA_WIDTH  working value driven to ALU DATA1.
REQ-011 SHALL have port ALU_DATA2  output  DATA_WIDTH  direction code to ALU DATA2.
REQ-012 SHALL have port ALU_SELECT  output  3  ALU function select.
REQ-013 SHALL have port ALU_RESULT  input  DATA_WIDTH  ALU result.
REQ-014 SHALL have ports BUSY, DONE, ERROR  output  1 each; RESULT  output  DATA_WIDTH  final value.

Function
REQ-015 SHALL implement FSM states IDLE, STEP, FIN; all outputs registered or decoded from state only.
REQ-016 IDLE + START=1 at edge E0: latch OPERAND into work register, AMOUNT into counter, OP/DIR into op register; go STEP if AMOUNT!=0 and OP!=11, else FIN.
REQ-017 In STEP: ALU_DATA1=work register; ALU_SELECT 101/110/111 for OP 00/01/10; ALU_DATA2=8'h01 for DIR=0, 8'h80 for DIR=1.
REQ-018 Outside STEP: ALU_SELECT=000, ALU_DATA1=0, ALU_DATA2=0.
REQ-019 Each STEP edge: work register <= ALU_RESULT, counter <= counter-1; counter==1 at that edge -> FIN.
REQ-020 FIN lasts exactly one cycle: DONE=1, RESULT <= work register, then IDLE.
REQ-021 Latency: DONE high in the cycle after edge E(AMOUNT); AMOUNT=0 -> DONE in cycle after E0, RESULT=OPERAND, no ALU step.
REQ-022 OP=11: no ALU step, FIN next cycle, ERROR=1 together with DONE, RESULT=OPERAND.
REQ-023 BUSY=1 in STEP and FIN; START ignored while BUSY=1; OPERAND/AMOUNT changes after E0 have no effect.
REQ-024 RESULT holds its value until the next FIN; DONE and ERROR are single-cycle pulses.
REQ-025 CLK period SHALL exceed the ALU worst-case delay of 2 time units; ALU_RESULT sampled one edge after ALU inputs change.

Reset
REQ-026 RESET=0 at a rising edge -> state IDLE; BUSY, DONE, ERROR=0; RESULT, work register, counter=0; ALU outputs per REQ-018.
REQ-027 RESET mid-operation aborts without DONE; RESET has priority over START and ABORT.

Configuration
REQ-028 Macro SHIFT_SEQ_ABORT_EN defined: adds input ABORT (1 bit); ABORT=1 in STEP -> IDLE at next edge, no DONE, RESULT unchanged; ABORT ignored in IDLE/FIN.
REQ-029 Macro SHIFT_SEQ_ABORT_EN undefined: no ABORT port; every accepted START ends in exactly one FIN.

Verification
REQ-030 OPERAND=8'h01, OP=00, DIR=0, AMOUNT=3 -> DONE 3 cycles after E0 +1, RESULT=8'h08, ALU_SELECT=101 for 3 cycles.
REQ-031 OPERAND=8'h81, OP=10, DIR=1, AMOUNT=1 -> RESULT=8'hC0, DONE one cycle after E1.
REQ-032 OPERAND=8'h5A, AMOUNT=0 -> DONE cycle after E0, RESULT=8'h5A, ALU_SELECT stays 000.
REQ-033 OP=11, OPERAND=8'h33 -> DONE and ERROR pulse together, RESULT=8'h33; second START during BUSY ignored.
REQ-034 RESET=0 during STEP of AMOUNT=7 -> IDLE next edge, no DONE, RESULT=0; with SHIFT_SEQ_ABORT_EN, ABORT mid-STEP -> IDLE, RESULT keeps prior value.
